lab1_response_checker: RTL and testbench

//  Synthesizable on-board self-test for the Lab1 4-input/1-output combinational function.

---
 rtl/lab1_pkg.sv | 13 +
 rtl/lab1_hold_timer.sv | 34 +++
 rtl/lab1_response_checker.sv | 136 +++++++++++++
 tb/tb_lab1_response_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_pkg.sv
// Shared types and sizes for the Lab1 response checker.
package lab1_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lab1_hold_timer.sv
// Per-vector hold counter; flags the last clock of each hold window.
module lab1_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign last = (hold_cnt_q == LAST_CNT);

  // Wraps to zero on the last cycle so it never exceeds HOLD_CYCLES-1.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (clr) begin
      hold_cnt_d = '0;
    end else if (en) begin
      hold_cnt_d = last ? '0 : CNT_W'(hold_cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end

endmodule

// File: rtl/lab1_response_checker.sv
// Sweeps all 16 ABCD vectors into the Lab1 DUT, captures F and grades it
// against a golden truth table.
module lab1_response_checker
  import lab1_pkg::*;
#(
  parameter int unsigned        HOLD_CYCLES = 50,
  parameter logic [NUM_VEC-1:0] EXPECTED    = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               f_in,
  output logic [VEC_W-1:0]   vec_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [4:0]         err_count,
  output logic [NUM_VEC-1:0] captured,
  output logic [VEC_W-1:0]   first_err_idx,
  output logic               first_err_valid
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [4:0]         err_q, err_d;
  logic [NUM_VEC-1:0] cap_q, cap_d;
  logic [VEC_W-1:0]   fidx_q, fidx_d;
  logic               fval_q, fval_d;

  logic timer_clr, timer_en, timer_last;
  logic mismatch;

  lab1_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .last (timer_last)
  );

  assign timer_en = (state_q == DRIVE);
  assign mismatch = (f_in != EXPECTED[vec_q]);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    cap_d     = cap_q;
    fidx_d    = fidx_q;
    fval_d    = fval_q;
    timer_clr = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // A new sweep wipes every result from the previous one.
        if (start) begin
          state_d   = DRIVE;
          vec_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          cap_d     = '0;
          fidx_d    = '0;
          fval_d    = 1'b0;
          timer_clr = 1'b1;
        end
      end
      DRIVE: begin
        if (timer_last) begin
          cap_d[vec_q] = f_in;
          if (mismatch) begin
            err_d = 5'(err_q + 5'd1);
            if (!fval_q) begin
              fidx_d = vec_q;
              fval_d = 1'b1;
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 5'd0);
          end else begin
            vec_d = VEC_W'(vec_q + VEC_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      cap_q   <= '0;
      fidx_q  <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
      fidx_q  <= fidx_d;
      fval_q  <= fval_d;
    end
  end

  assign vec_out         = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign captured        = cap_q;
  assign first_err_idx   = fidx_q;
  assign first_err_valid = fval_q;

endmodule

// File: tb/tb_lab1_response_checker.sv
// Scoreboard bench: each accepted sweep pushes its graded result, a monitor
// pops it when done rises and also polices per-vector hold timing.
module tb_lab1_response_checker;

  localparam int unsigned H    = 4;
  localparam logic [15:0] GOLD = 16'hF444;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic [15:0] tbl, tbl2;
  logic        f_in, f_in2;

  logic [3:0]  vec_out, vec_out2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [4:0]  err_count, err_count2;
  logic [15:0] captured, captured2;
  logic [3:0]  first_err_idx, first_err_idx2;
  logic        first_err_valid, first_err_valid2;

  assign f_in  = tbl[vec_out];
  assign f_in2 = tbl2[vec_out2];

  lab1_response_checker #(.HOLD_CYCLES(H), .EXPECTED(GOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .f_in(f_in), .vec_out(vec_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .captured(captured), .first_err_idx(first_err_idx),
    .first_err_valid(first_err_valid)
  );

  lab1_response_checker #(.HOLD_CYCLES(2), .EXPECTED(GOLD)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .f_in(f_in2), .vec_out(vec_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .captured(captured2), .first_err_idx(first_err_idx2),
    .first_err_valid(first_err_valid2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] cap;
    int          errs;
    int          fidx;
    bit          fval;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int first_idx(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Reference grading from the truth-table definition alone.
  task automatic issue(input logic [15:0] t);
    exp_t e;
    @(negedge clk);
    tbl   = t;
    start = 1'b1;
    e.cap     = t;
    e.errs    = $countones(t ^ GOLD);
    e.fidx    = first_idx(t ^ GOLD);
    e.fval    = ((t ^ GOLD) != 16'h0);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor state, owned by the monitor process only.
  logic       prev_done = 1'b0;
  logic       prev_busy = 1'b0;
  int         run = 0;
  logic [3:0] last_vec = 4'h0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (!done) chk("pass_without_done", 32'(pass), 32'd0);
      if (busy && !prev_busy) begin
        run      = 1;
        last_vec = vec_out;
        chk("first_vec", 32'(vec_out), 32'd0);
      end else if (busy) begin
        if (vec_out == last_vec) run++;
        else begin
          chk("hold_len", run, H);
          chk("vec_step", 32'(vec_out), 32'(4'(last_vec + 4'd1)));
          last_vec = vec_out;
          run      = 1;
        end
      end else if (prev_busy && done) begin
        chk("hold_len_last", run, H);
      end
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no sweep pending");
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc_cyc, 16 * H);
          chk("captured", 32'(captured), 32'(e.cap));
          chk("err_count", 32'(err_count), e.errs);
          chk("first_err_valid", 32'(first_err_valid), 32'(e.fval));
          if (e.fval) chk("first_err_idx", 32'(first_err_idx), e.fidx);
          chk("pass", 32'(pass), 32'(e.errs == 0));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("vec_at_done", 32'(vec_out), 32'd15);
        end
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    start  = 1'b0;
    start2 = 1'b0;
    tbl    = GOLD;
    tbl2   = 16'h0;
    rst    = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_vec", 32'(vec_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_cap", 32'(captured), 32'd0);
    chk("rst_fidx", 32'(first_err_idx), 32'd0);
    chk("rst_fval", 32'(first_err_valid), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Correct DUT, then F stuck low.
    issue(GOLD);
    wait_drain(200);
    issue(16'h0000);
    wait_drain(200);

    // A second start mid-sweep must be ignored.
    issue(GOLD);
    repeat (18) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(200);

    // Asynchronous reset at vector 7 with errors already counted.
    issue(16'h0000);
    n = 0;
    while (vec_out != 4'd7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec7", 32'(vec_out), 32'd7);
    chk("pre_rst_err", 32'(err_count), $countones(GOLD & 16'h007F));
    #2 rst = 1'b1;
    #1;
    chk("async_vec", 32'(vec_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_err", 32'(err_count), 32'd0);
    chk("async_cap", 32'(captured), 32'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    issue(GOLD);
    wait_drain(200);

    // Back-to-back from DONE with the inverted DUT.
    issue(~GOLD);
    chk("b2b_done", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_err", 32'(err_count), 32'd0);
    chk("b2b_cap", 32'(captured), 32'd0);
    chk("b2b_fval", 32'(first_err_valid), 32'd0);
    wait_drain(200);

    // Random truth tables.
    for (int k = 0; k < 4; k++) begin
      issue(16'($urandom));
      wait_drain(200);
    end

    // Minimum hold length instance.
    @(negedge clk);
    tbl2   = 16'($urandom);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("h2_latency", n, 32);
    chk("h2_captured", 32'(captured2), 32'(tbl2));
    chk("h2_err", 32'(err_count2), $countones(tbl2 ^ GOLD));
    chk("h2_pass", 32'(pass2), 32'(tbl2 == GOLD));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
